// File: rtl/mem_arbiter_pkg.sv
// Shared MIPS memory-bus definitions: arbiter FSM states, bus owner encoding,
// access size encoding and the latched command payload used by mem_arbiter.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SIZE_W = 2;

    // Arbiter FSM states: one bus transaction outstanding at most.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    // Which requester currently owns the shared bus.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    // Bus access size.
    typedef enum logic [SIZE_W-1:0] {
        MSIZE_BYTE = 2'd0,
        MSIZE_HALF = 2'd1,
        MSIZE_WORD = 2'd2
    } msize_t;

    // Command fields captured at grant time and replayed on the bus.
    typedef struct packed {
        logic              wr;
        msize_t            size;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

    function automatic mem_cmd_t make_cmd(
        input logic              wr,
        input msize_t            size,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] wdata
    );
        mem_cmd_t c;
        c.wr    = wr;
        c.size  = size;
        c.addr  = addr;
        c.wdata = wdata;
        return c;
    endfunction

endpackage : mem_arbiter_pkg

// File: rtl/mem_arbiter.sv
// Two-master arbiter (instruction fetch side I, memory stage side D) in front
// of a single shared memory bus. D normally wins; a starve counter forces an
// I grant after STARVE_LIMIT consecutive D grants taken while I was waiting.
//
// Ports:
//   clk, reset             clock, asynchronous active-low reset
//   i_req/i_addr           fetch request (held until i_addr_ok)
//   i_addr_ok/i_data_ok    fetch accept / data-valid pulses, i_rdata data
//   d_req/d_wr/d_size/d_addr/d_wdata   data-side request and command fields
//   d_addr_ok/d_data_ok    data accept / completion pulses, d_rdata data
//   m_req/m_wr/m_size/m_addr/m_wdata   shared-bus command (from latched fields)
//   m_addr_ok/m_data_ok/m_rdata        shared-bus handshakes and read data
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_addr_ok,
    output logic              i_data_ok,
    output logic [DATA_W-1:0] i_rdata,

    input  logic              d_req,
    input  logic              d_wr,
    input  logic [SIZE_W-1:0] d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_addr_ok,
    output logic              d_data_ok,
    output logic [DATA_W-1:0] d_rdata,

    output logic              m_req,
    output logic              m_wr,
    output logic [SIZE_W-1:0] m_size,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_addr_ok,
    input  logic              m_data_ok,
    input  logic [DATA_W-1:0] m_rdata
);

    localparam int unsigned STARVE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    arb_state_t          state_q,  state_d;
    owner_t              owner_q,  owner_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    mem_cmd_t            cmd_q,    cmd_d;

    logic starve_full;
    logic pick_i;
    logic pick_d;
    logic bus_done;

    // Grant selection: D first unless I has waited through STARVE_LIMIT D grants.
    always_comb begin
        starve_full = (starve_q == STARVE_W'(STARVE_LIMIT));
        pick_i      = i_req && (!d_req || starve_full);
        pick_d      = d_req && !pick_i;
    end

    // Data phase completes in DATA, or in ADDR when both handshakes coincide.
    always_comb begin
        bus_done = m_data_ok &&
                   ((state_q == DATA) || ((state_q == ADDR) && m_addr_ok));
    end

    // Next-state, command latch, starve counter and accept pulses.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        starve_d  = starve_q;
        cmd_d     = cmd_q;
        i_addr_ok = 1'b0;
        d_addr_ok = 1'b0;
        m_req     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Accept pulses are suppressed while reset is asserted.
                if (reset && pick_i) begin
                    i_addr_ok = 1'b1;
                    owner_d   = OWN_I;
                    cmd_d     = make_cmd(1'b0, MSIZE_WORD, i_addr, '0);
                    starve_d  = '0;
                    state_d   = ADDR;
                end else if (reset && pick_d) begin
                    d_addr_ok = 1'b1;
                    owner_d   = OWN_D;
                    cmd_d     = make_cmd(d_wr, msize_t'(d_size), d_addr, d_wdata);
                    if (i_req && !starve_full) begin
                        starve_d = starve_q + STARVE_W'(1);
                    end
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                m_req = 1'b1;
                if (m_addr_ok) begin
                    if (m_data_ok) begin
                        state_d = IDLE;
                        owner_d = OWN_NONE;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (m_data_ok) begin
                    state_d = IDLE;
                    owner_d = OWN_NONE;
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    // Completion is steered to the owner only; read data is broadcast.
    always_comb begin
        i_data_ok = bus_done && (owner_q == OWN_I);
        d_data_ok = bus_done && (owner_q == OWN_D);
        i_rdata   = m_rdata;
        d_rdata   = m_rdata;
    end

    // Bus command always comes from the latch, never from live request inputs.
    always_comb begin
        m_wr    = cmd_q.wr;
        m_size  = cmd_q.size;
        m_addr  = cmd_q.addr;
        m_wdata = cmd_q.wdata;
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            owner_q  <= OWN_NONE;
            starve_q <= '0;
            cmd_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
            cmd_q    <= cmd_d;
        end
    end

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter. Inputs change on the falling
// edge; outputs are sampled 1 time unit later.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_addr_ok;
    logic        i_data_ok;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_wr;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_addr_ok;
    logic        d_data_ok;
    logic [31:0] d_rdata;
    logic        m_req;
    logic        m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_addr_ok;
    logic        m_data_ok;
    logic [31:0] m_rdata;

    int n_checks;
    int n_fail;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_addr_ok (i_addr_ok),
        .i_data_ok (i_data_ok),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_wr      (d_wr),
        .d_size    (d_size),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_addr_ok (d_addr_ok),
        .d_data_ok (d_data_ok),
        .d_rdata   (d_rdata),
        .m_req     (m_req),
        .m_wr      (m_wr),
        .m_size    (m_size),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_addr_ok (m_addr_ok),
        .m_data_ok (m_data_ok),
        .m_rdata   (m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_wr = 1'b0; d_size = 2'd0; d_addr = '0; d_wdata = '0;
        m_addr_ok = 1'b0; m_data_ok = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        m_rdata = 32'h1234_5678;
        @(negedge clk);
        i_req = 1'b1; d_req = 1'b1; m_addr_ok = 1'b1; m_data_ok = 1'b1;
        #1;
        n_checks++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL rst_m_req: got %b exp 0", m_req); end
        n_checks++; if (i_addr_ok !== 1'b0) begin n_fail++; $display("FAIL rst_i_addr_ok: got %b exp 0", i_addr_ok); end
        n_checks++; if (d_addr_ok !== 1'b0) begin n_fail++; $display("FAIL rst_d_addr_ok: got %b exp 0", d_addr_ok); end
        n_checks++; if (i_data_ok !== 1'b0) begin n_fail++; $display("FAIL rst_i_data_ok: got %b exp 0", i_data_ok); end
        n_checks++; if (d_data_ok !== 1'b0) begin n_fail++; $display("FAIL rst_d_data_ok: got %b exp 0", d_data_ok); end
        n_checks++; if (m_addr !== 32'h0) begin n_fail++; $display("FAIL rst_m_addr: got %h exp 0", m_addr); end
        n_checks++; if (m_wdata !== 32'h0 || m_wr !== 1'b0 || m_size !== 2'd0) begin n_fail++; $display("FAIL rst_m_cmd: got wr=%b size=%0d wdata=%h exp 0", m_wr, m_size, m_wdata); end
        n_checks++; if (i_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL rst_i_rdata: got %h exp 12345678", i_rdata); end
        n_checks++; if (d_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL rst_d_rdata: got %h exp 12345678", d_rdata); end
        @(negedge clk);
        #1;
        n_checks++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL rst_hold_m_req: got %b exp 0", m_req); end
        idle_inputs();
        reset = 1'b1;
    endtask

    task automatic test_single_fetch();
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'hBFC0_0000;
        #1;
        n_checks++; if (i_addr_ok !== 1'b1) begin n_fail++; $display("FAIL fetch_i_addr_ok: got %b exp 1", i_addr_ok); end
        n_checks++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL fetch_m_req_idle: got %b exp 0", m_req); end
        @(negedge clk);
        i_req = 1'b0; i_addr = 32'h0;
        #1;
        n_checks++; if (m_req !== 1'b1) begin n_fail++; $display("FAIL fetch_m_req: got %b exp 1", m_req); end
        n_checks++; if (m_addr !== 32'hBFC0_0000) begin n_fail++; $display("FAIL fetch_m_addr: got %h exp bfc00000", m_addr); end
        n_checks++; if (m_wr !== 1'b0 || m_size !== 2'd2) begin n_fail++; $display("FAIL fetch_m_cmd: got wr=%b size=%0d exp wr=0 size=2", m_wr, m_size); end
        n_checks++; if (i_addr_ok !== 1'b0) begin n_fail++; $display("FAIL fetch_single_pulse: got %b exp 0", i_addr_ok); end
        @(negedge clk);
        m_addr_ok = 1'b1;
        #1;
        n_checks++; if (m_req !== 1'b1) begin n_fail++; $display("FAIL fetch_m_req_2: got %b exp 1", m_req); end
        @(negedge clk);
        m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'h3C08_0001;
        #1;
        n_checks++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL fetch_m_req_data: got %b exp 0", m_req); end
        n_checks++; if (i_data_ok !== 1'b1) begin n_fail++; $display("FAIL fetch_i_data_ok: got %b exp 1", i_data_ok); end
        n_checks++; if (i_rdata !== 32'h3C08_0001) begin n_fail++; $display("FAIL fetch_i_rdata: got %h exp 3c080001", i_rdata); end
        n_checks++; if (d_data_ok !== 1'b0) begin n_fail++; $display("FAIL fetch_d_data_ok: got %b exp 0", d_data_ok); end
        n_checks++; if (i_addr_ok !== 1'b0) begin n_fail++; $display("FAIL fetch_no_extra_addr_ok: got %b exp 0", i_addr_ok); end
        @(negedge clk);
        m_data_ok = 1'b0;
        #1;
        n_checks++; if (i_data_ok !== 1'b0 || m_req !== 1'b0) begin n_fail++; $display("FAIL fetch_end_idle: got data_ok=%b m_req=%b exp 0 0", i_data_ok, m_req); end
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'hBFC0_0004;
        d_req = 1'b1; d_wr = 1'b1; d_size = 2'd2; d_addr = 32'h8000_1000; d_wdata = 32'hDEAD_BEEF;
        #1;
        n_checks++; if (d_addr_ok !== 1'b1 || i_addr_ok !== 1'b0) begin n_fail++; $display("FAIL sim_grant_d: got d=%b i=%b exp d=1 i=0", d_addr_ok, i_addr_ok); end
        @(negedge clk);
        d_req = 1'b0;
        #1;
        n_checks++; if (m_req !== 1'b1 || m_wr !== 1'b1) begin n_fail++; $display("FAIL sim_m_req_wr: got req=%b wr=%b exp 1 1", m_req, m_wr); end
        n_checks++; if (m_addr !== 32'h8000_1000 || m_wdata !== 32'hDEAD_BEEF || m_size !== 2'd2) begin n_fail++; $display("FAIL sim_m_cmd: got addr=%h wdata=%h size=%0d exp 80001000 deadbeef 2", m_addr, m_wdata, m_size); end
        n_checks++; if (i_addr_ok !== 1'b0) begin n_fail++; $display("FAIL sim_i_wait_addr: got %b exp 0", i_addr_ok); end
        m_addr_ok = 1'b1;
        @(negedge clk);
        m_addr_ok = 1'b0; m_data_ok = 1'b1;
        #1;
        n_checks++; if (d_data_ok !== 1'b1 || i_data_ok !== 1'b0) begin n_fail++; $display("FAIL sim_d_done: got d=%b i=%b exp d=1 i=0", d_data_ok, i_data_ok); end
        n_checks++; if (i_addr_ok !== 1'b0) begin n_fail++; $display("FAIL sim_i_wait_data: got %b exp 0", i_addr_ok); end
        @(negedge clk);
        m_data_ok = 1'b0;
        #1;
        n_checks++; if (i_addr_ok !== 1'b1 || m_req !== 1'b0) begin n_fail++; $display("FAIL sim_i_grant_gap: got addr_ok=%b m_req=%b exp 1 0", i_addr_ok, m_req); end
        @(negedge clk);
        i_req = 1'b0;
        #1;
        n_checks++; if (m_req !== 1'b1 || m_addr !== 32'hBFC0_0004 || m_wr !== 1'b0) begin n_fail++; $display("FAIL sim_i_cmd: got req=%b addr=%h wr=%b exp 1 bfc00004 0", m_req, m_addr, m_wr); end
        m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'h2408_0002;
        #1;
        n_checks++; if (i_data_ok !== 1'b1 || d_data_ok !== 1'b0) begin n_fail++; $display("FAIL sim_i_done: got i=%b d=%b exp i=1 d=0", i_data_ok, d_data_ok); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_same_cycle();
        @(negedge clk);
        d_req = 1'b1; d_wr = 1'b0; d_size = 2'd0; d_addr = 32'h8000_0040;
        #1;
        n_checks++; if (d_addr_ok !== 1'b1) begin n_fail++; $display("FAIL same_d_addr_ok: got %b exp 1", d_addr_ok); end
        @(negedge clk);
        d_req = 1'b0; m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'h0000_00A5;
        #1;
        n_checks++; if (d_data_ok !== 1'b1 || d_rdata !== 32'h0000_00A5) begin n_fail++; $display("FAIL same_d_data: got ok=%b rdata=%h exp 1 000000a5", d_data_ok, d_rdata); end
        n_checks++; if (m_req !== 1'b1 || m_size !== 2'd0) begin n_fail++; $display("FAIL same_m_req: got req=%b size=%0d exp 1 0", m_req, m_size); end
        @(negedge clk);
        #1;
        // Back in IDLE with stray bus handshakes still asserted: they must be ignored.
        n_checks++; if (m_req !== 1'b0 || d_data_ok !== 1'b0 || i_data_ok !== 1'b0) begin n_fail++; $display("FAIL same_idle_ignore: got req=%b d=%b i=%b exp 0 0 0", m_req, d_data_ok, i_data_ok); end
        @(negedge clk);
        #1;
        n_checks++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL idle_addr_ok_ignored: got %b exp 0", m_req); end
        idle_inputs();
    endtask

    task automatic test_starvation();
        logic exp_i;
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'hBFC0_0100;
        d_req = 1'b1; d_wr = 1'b0; d_size = 2'd2; d_addr = 32'h8000_0200;
        for (int k = 0; k < 11; k++) begin
            exp_i = (k == 4) || (k == 9);
            #1;
            n_checks++; if (i_addr_ok !== exp_i || d_addr_ok !== !exp_i) begin n_fail++; $display("FAIL starve_grant_%0d: got i=%b d=%b exp i=%b d=%b", k, i_addr_ok, d_addr_ok, exp_i, !exp_i); end
            @(negedge clk);
            m_addr_ok = 1'b1; m_data_ok = 1'b1;
            #1;
            n_checks++; if (i_data_ok !== exp_i || d_data_ok !== !exp_i) begin n_fail++; $display("FAIL starve_done_%0d: got i=%b d=%b exp i=%b d=%b", k, i_data_ok, d_data_ok, exp_i, !exp_i); end
            @(negedge clk);
            m_addr_ok = 1'b0; m_data_ok = 1'b0;
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        d_req = 1'b1; d_wr = 1'b0; d_size = 2'd2; d_addr = 32'h8000_2000;
        #1;
        n_checks++; if (d_addr_ok !== 1'b1) begin n_fail++; $display("FAIL rmid_d_addr_ok: got %b exp 1", d_addr_ok); end
        @(negedge clk);
        d_req = 1'b0; m_addr_ok = 1'b1;
        @(negedge clk);
        m_addr_ok = 1'b0;
        #1;
        n_checks++; if (m_req !== 1'b0 || m_addr !== 32'h8000_2000) begin n_fail++; $display("FAIL rmid_in_data: got req=%b addr=%h exp 0 80002000", m_req, m_addr); end
        reset = 1'b0; m_data_ok = 1'b1; d_req = 1'b1; i_req = 1'b1; m_rdata = 32'hCAFE_F00D;
        #1;
        n_checks++; if (d_data_ok !== 1'b0 || i_data_ok !== 1'b0) begin n_fail++; $display("FAIL rmid_no_data_ok: got d=%b i=%b exp 0 0", d_data_ok, i_data_ok); end
        n_checks++; if (d_addr_ok !== 1'b0 || i_addr_ok !== 1'b0) begin n_fail++; $display("FAIL rmid_no_addr_ok: got d=%b i=%b exp 0 0", d_addr_ok, i_addr_ok); end
        n_checks++; if (m_req !== 1'b0 || m_addr !== 32'h0 || m_wdata !== 32'h0) begin n_fail++; $display("FAIL rmid_bus_cleared: got req=%b addr=%h wdata=%h exp 0 0 0", m_req, m_addr, m_wdata); end
        n_checks++; if (d_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL rmid_rdata: got %h exp cafef00d", d_rdata); end
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'hBFC0_0100;
        #1;
        n_checks++; if (i_addr_ok !== 1'b1) begin n_fail++; $display("FAIL rmid_after_grant: got %b exp 1", i_addr_ok); end
        @(negedge clk);
        i_req = 1'b0; m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'h1111_2222;
        #1;
        n_checks++; if (m_addr !== 32'hBFC0_0100 || i_data_ok !== 1'b1 || i_rdata !== 32'h1111_2222) begin n_fail++; $display("FAIL rmid_after_done: got addr=%h ok=%b rdata=%h exp bfc00100 1 11112222", m_addr, i_data_ok, i_rdata); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_latch();
        @(negedge clk);
        d_req = 1'b1; d_wr = 1'b1; d_size = 2'd2; d_addr = 32'h8000_1000; d_wdata = 32'hDEAD_BEEF;
        #1;
        n_checks++; if (d_addr_ok !== 1'b1) begin n_fail++; $display("FAIL latch_d_addr_ok: got %b exp 1", d_addr_ok); end
        @(negedge clk);
        d_req = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_wr = 1'b0; d_size = 2'd0;
        #1;
        n_checks++; if (m_addr !== 32'h8000_1000) begin n_fail++; $display("FAIL latch_m_addr: got %h exp 80001000", m_addr); end
        n_checks++; if (m_wr !== 1'b1 || m_wdata !== 32'hDEAD_BEEF || m_size !== 2'd2) begin n_fail++; $display("FAIL latch_m_cmd: got wr=%b wdata=%h size=%0d exp 1 deadbeef 2", m_wr, m_wdata, m_size); end
        @(negedge clk);
        m_addr_ok = 1'b1;
        #1;
        n_checks++; if (m_req !== 1'b1 || m_addr !== 32'h8000_1000) begin n_fail++; $display("FAIL latch_m_addr_2: got req=%b addr=%h exp 1 80001000", m_req, m_addr); end
        @(negedge clk);
        m_addr_ok = 1'b0; m_data_ok = 1'b1;
        #1;
        n_checks++; if (d_data_ok !== 1'b1 || i_data_ok !== 1'b0) begin n_fail++; $display("FAIL latch_d_done: got d=%b i=%b exp 1 0", d_data_ok, i_data_ok); end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        m_rdata  = '0;
        idle_inputs();
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_same_cycle();
        test_starvation();
        test_reset_mid();
        test_latch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mem_arbiter

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive D-side grants allowed while I-side waits before I-side is forced to win.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  asynchronous, active-low reset; all state is cleared while low.
REQ-004 i_req  in  1  fetch read request; held until i_addr_ok.
REQ-005 i_addr  in  32  fetch address.
REQ-006 i_addr_ok  out  1  one-cycle pulse: fetch request accepted.
REQ-007 i_data_ok  out  1  one-cycle pulse: i_rdata valid.
REQ-008 i_rdata  out  32  fetch read data.
REQ-009 d_req  in  1  memory-stage request; held until d_addr_ok.
REQ-010 d_wr  in  1  1 = write, 0 = read.
REQ-011 d_size  in  2  0 = byte, 1 = half, 2 = word.
REQ-012 d_addr  in  32  data address.
REQ-013 d_wdata  in  32  write data.
REQ-014 d_addr_ok  out  1  one-cycle pulse: data request accepted.
REQ-015 d_data_ok  out  1  one-cycle pulse: read data valid or write complete.
REQ-016 d_rdata  out  32  data read data.
REQ-017 m_req  out  1  shared-bus request.
REQ-018 m_wr, m_size, m_addr, m_wdata  out  1/2/32/32  shared-bus command fields.
REQ-019 m_addr_ok  in  1  bus accepted the command.
REQ-020 m_data_ok  in  1  bus data phase complete.
REQ-021 m_rdata  in  32  bus read data.

Function
REQ-022 SHALL implement FSM states IDLE, ADDR, DATA, with one outstanding bus transaction at most.
REQ-023 IDLE: any request grants that side, latches its command fields into registers, pulses that side's *_addr_ok in the same cycle, and moves to ADDR.
REQ-024 Priority: d_req wins over i_req, except when the starve counter equals STARVE_LIMIT; then i_req wins.
REQ-025 Starve counter: increments on each D grant while i_req is high, clears on each I grant, and saturates at STARVE_LIMIT.
REQ-026 ADDR: m_req = 1, and m_* is driven only from the latched registers; when m_addr_ok = 1, drop m_req and go to DATA.
REQ-027 m_addr_ok and m_data_ok high in the same ADDR cycle: go directly to IDLE and deliver the data_ok per REQ-028.
REQ-028 DATA: m_data_ok is forwarded combinationally to the owner's *_data_ok; m_rdata passes combinationally to the owner's *_rdata; the state then returns to IDLE.
REQ-029 The non-owner's *_data_ok SHALL be 0 at all times; both *_rdata outputs SHALL carry m_rdata.
REQ-030 Latency: request at edge t -> m_req high from t+1; data_ok in the same cycle as m_data_ok; a minimum 1-cycle IDLE gap between transactions.
REQ-031 Request inputs changing after *_addr_ok SHALL have no effect on the transaction in flight.
REQ-032 m_data_ok in IDLE SHALL be ignored; m_addr_ok outside ADDR SHALL be ignored.

Reset
REQ-033 While reset = 0: state = IDLE, owner = none, starve counter = 0, latched fields = 0, and all outputs = 0 except *_rdata, which follow m_rdata.
REQ-034 Reset mid-transaction abandons it with no data_ok; the bus slave shares the same reset.

Structure
REQ-035 arb_state_t (IDLE/ADDR/DATA), owner_t (NONE/I/D) and msize_t belong in the shared MIPS package.
REQ-036 No sub-module is needed; the FSM, starve counter and command latch live in mem_arbiter.

Verification
REQ-037 Single fetch: i_req, i_addr = 0xBFC00000; m_addr_ok after 2 cycles; m_data_ok, m_rdata = 0x3C080001 one cycle later -> one i_addr_ok pulse, m_addr = 0xBFC00000, i_data_ok with i_rdata = 0x3C080001, d_data_ok = 0.
REQ-038 Simultaneous i_req and d_req (d_wr = 1, d_addr = 0x80001000, d_wdata = 0xDEADBEEF, size 2) -> D granted first with m_wr = 1; I granted after d_data_ok plus the IDLE gap.
REQ-039 Starvation: d_req held high with i_req high and STARVE_LIMIT = 4 -> four D grants, then an I grant, then the counter back at 0.
REQ-040 Same-cycle m_addr_ok and m_data_ok on a D read -> d_data_ok in that cycle, then IDLE on the next edge.
REQ-041 Reset driven low in DATA state -> all outputs 0 immediately, no data_ok, and the next request is served normally after release.
REQ-042 d_addr changed to 0x0 after d_addr_ok -> m_addr still shows the latched 0x80001000.
